// File: rtl/norm_pkg.sv
// Shared state and mode encodings for the sequential normalizer.
package norm_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    localparam logic [1:0] MODE_LEFT  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;

endpackage

// File: rtl/norm_step.sv
// One normalization step: next shifted word and whether to stop now.
// Mode 10 uses redundant-sign-bit stopping only when SEQ_NORMALIZER_ARITH_EN is defined.
module norm_step
    import norm_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] next_o,
    output logic             stop_o
);

    logic is_zero;
    assign is_zero = (word_i == '0);

`ifndef SEQ_NORMALIZER_ARITH_EN
    logic unused_cnt;
    assign unused_cnt = ^cnt_i;
`endif

    // Mode 11 and, in the default build, mode 10 fall through to left-logical.
    always_comb begin
        next_o = word_i << 1;
        stop_o = word_i[WIDTH-1] | is_zero;
        if (mode_i == MODE_RIGHT) begin
            next_o = word_i >> 1;
            stop_o = word_i[0] | is_zero;
        end
`ifdef SEQ_NORMALIZER_ARITH_EN
        else if (mode_i == MODE_ARITH) begin
            stop_o = (word_i[WIDTH-1] != word_i[WIDTH-2]) | is_zero |
                     (cnt_i == CNT_W'(WIDTH - 1));
        end
`endif
    end

endmodule

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: shifts one bit per clock until normalized, reports word and count.
// Optional SEQ_NORMALIZER_ARITH_EN enables left-arithmetic normalization for mode 10.
module seq_normalizer
    import norm_pkg::*;
#(
    parameter int unsigned  WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] shamt,
    output logic             zero
);

    state_e           state_q;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic             busy_q, done_q, zero_q;
    logic [WIDTH-1:0] dout_q;
    logic [CNT_W-1:0] shamt_q;

    logic [WIDTH-1:0] word_d;
    logic             stop;

    norm_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .word_i (word_q),
        .mode_i (mode_q),
        .cnt_i  (cnt_q),
        .next_o (word_d),
        .stop_o (stop)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_LEFT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        word_q  <= din;
                        cnt_q   <= '0;
                        mode_q  <= mode;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (stop) begin
                        dout_q  <= word_q;
                        shamt_q <= cnt_q;
                        zero_q  <= (word_q == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        word_q <= word_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign dout  = dout_q;
    assign shamt = shamt_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Randomized self-checking bench for seq_normalizer against a counting reference model.
module tb_seq_normalizer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] din = '0;
    logic         busy, done, zero;
    logic [W-1:0] dout;
    logic [2:0]   shamt;

    int n_cmp = 0;
    int n_err = 0;

    seq_normalizer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .shamt (shamt),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of single-bit shifts needed, derived by counting bits of the original word.
    function automatic int model_k(input logic [W-1:0] d, input logic [1:0] m);
        int k = 0;
        if (d == '0) return 0;
        if (m == 2'b01) begin
            while (d[k] == 1'b0) k++;
            return k;
        end
`ifdef SEQ_NORMALIZER_ARITH_EN
        if (m == 2'b10) begin
            for (int i = W - 2; i >= 0; i--) begin
                if (d[i] != d[W-1]) break;
                k++;
            end
            return k;
        end
`endif
        while (d[W-1-k] == 1'b0) k++;
        return k;
    endfunction

    function automatic logic [W-1:0] model_dout(input logic [W-1:0] d, input logic [1:0] m);
        int k = model_k(d, m);
        return (m == 2'b01) ? (d >> k) : (d << k);
    endfunction

    // Present a job at the current negedge; acceptance happens on the next posedge.
    task automatic issue(input logic [W-1:0] d, input logic [1:0] m);
        start = 1'b1;
        din   = d;
        mode  = m;
        @(negedge clk);
    endtask

    // Wait for done while scrambling inputs; returns at the negedge of the done cycle.
    task automatic wait_check(input string tag, input logic [W-1:0] d, input logic [1:0] m,
                              input logic noise);
        int cyc = 0;
        int busy_cyc = 0;
        while (!done && cyc < 20) begin
            cyc++;
            if (busy) busy_cyc++;
            start = noise ? 1'($urandom) : 1'b0;
            din   = noise ? W'($urandom) : din;
            mode  = noise ? 2'($urandom) : mode;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_lat"},   cyc, model_k(d, m) + 1);
        check({tag, "_busyc"}, busy_cyc, model_k(d, m) + 1);
        check({tag, "_done"},  done, 1);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_dout"},  dout, model_dout(d, m));
        check({tag, "_shamt"}, shamt, model_k(d, m));
        check({tag, "_zero"},  zero, d == '0);
    endtask

    task automatic job(input string tag, input logic [W-1:0] d, input logic [1:0] m);
        issue(d, m);
        wait_check(tag, d, m, 1'b1);
    endtask

    initial begin
        int pulses;
        logic [W-1:0] rd;
        logic [1:0]   rm;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_shamt", shamt, 0);
        check("rst_zero", zero, 0);
        rst = 1'b1;
        @(negedge clk);

        job("t1", 8'h13, 2'b00);
        job("t2", 8'hA8, 2'b01);
        job("t3", 8'h01, 2'b00);
        // Back-to-back: start in the done cycle.
        issue(8'h80, 2'b00);
        wait_check("t3b", 8'h80, 2'b00, 1'b0);
        check("t3b_shamt_lit", shamt, 0);
        job("t4a", 8'h00, 2'b00);
        job("t4b", 8'h00, 2'b01);
        job("t6a", 8'hF3, 2'b10);
        job("t6b", 8'hFF, 2'b10);
        job("t6c", 8'h10, 2'b11);

        // Reset mid-operation discards the job.
        issue(8'h02, 2'b00);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_dout", dout, 0);
        check("t5_shamt", shamt, 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("t5_nodone", pulses, 0);
        job("t5b", 8'h40, 2'b00);

        for (int i = 0; i < 150; i++) begin
            rd = W'($urandom);
            if ($urandom_range(0, 7) == 0) rd = '0;
            rm = 2'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                job("rnd", rd, rm);
            end else begin
                issue(rd, rm);
                wait_check("rndq", rd, rm, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
